// File: rtl/subtractor.sv
// Pipelined full-precision subtractor: data_o = data1_i - data2_i, widened by one bit.
// S1 registers the extended operands, S2 registers the difference and its sign.
module subtractor #(
    parameter bit SIGNED       = 1'b1,
    parameter int DATA_WIDTH_1 = 16,
    parameter int DATA_WIDTH_2 = 16,
    localparam int OUT_WIDTH   = ((DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DATA_WIDTH_1-1:0] data1_i,
    input  logic [DATA_WIDTH_2-1:0] data2_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [OUT_WIDTH-1:0]    data_o,
    output logic                    borrow_o
);

    logic                 s1_valid;
    logic [OUT_WIDTH-1:0] s1_a;
    logic [OUT_WIDTH-1:0] s1_b;
    logic                 s2_valid;
    logic [OUT_WIDTH-1:0] s2_diff;
    logic                 s2_borrow;
    logic                 s2_can_load;
    logic [OUT_WIDTH-1:0] ext1;
    logic [OUT_WIDTH-1:0] ext2;
    logic [OUT_WIDTH-1:0] diff;

    // Handshake: a word moves across a boundary on any rising edge where the
    // sender's valid and the receiver's ready are both high. A stage holds its
    // word until it moves on, and a stage may load and drain in the same cycle.
    assign s2_can_load = !s2_valid || ready_i;
    assign ready_o     = !s1_valid || s2_can_load;

    always_comb begin
        ext1 = {{(OUT_WIDTH-DATA_WIDTH_1){SIGNED & data1_i[DATA_WIDTH_1-1]}}, data1_i};
        ext2 = {{(OUT_WIDTH-DATA_WIDTH_2){SIGNED & data2_i[DATA_WIDTH_2-1]}}, data2_i};
        diff = s1_a - s1_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_valid  <= 1'b0;
            s2_diff   <= '0;
            s2_borrow <= 1'b0;
        end else begin
            if (s2_can_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_diff   <= diff;
                    s2_borrow <= diff[OUT_WIDTH-1];
                end
            end
            // S1 empties when it drains with no new operand behind it.
            if (ready_o) begin
                s1_valid <= valid_i;
                if (valid_i) begin
                    s1_a <= ext1;
                    s1_b <= ext2;
                end
            end
        end
    end

    assign valid_o  = s2_valid;
    assign data_o   = s2_diff;
    assign borrow_o = s2_borrow;

endmodule

// File: tb/tb_subtractor.sv
// Bench for subtractor: signed 16/16, unsigned 16/16 and unsigned 8/12 instances
// share one handshake stream; each is scored against an integer-arithmetic model.
module tb_subtractor;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_i;
    logic [15:0] data1;
    logic [15:0] data2;

    logic        rdy_s, vo_s, b_s;
    logic [16:0] d_s;
    logic        rdy_u, vo_u, b_u;
    logic [16:0] d_u;
    logic        rdy_m, vo_m, b_m;
    logic [12:0] d_m;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] exp_s_q[$];
    logic [17:0] exp_u_q[$];
    logic [13:0] exp_m_q[$];
    logic        prev_hold;
    logic [17:0] prev_s;

    subtractor #(.SIGNED(1'b1), .DATA_WIDTH_1(16), .DATA_WIDTH_2(16)) u_s (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_s),
        .data1_i(data1), .data2_i(data2), .valid_o(vo_s), .ready_i(ready_i),
        .data_o(d_s), .borrow_o(b_s));

    subtractor #(.SIGNED(1'b0), .DATA_WIDTH_1(16), .DATA_WIDTH_2(16)) u_u (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_u),
        .data1_i(data1), .data2_i(data2), .valid_o(vo_u), .ready_i(ready_i),
        .data_o(d_u), .borrow_o(b_u));

    subtractor #(.SIGNED(1'b0), .DATA_WIDTH_1(8), .DATA_WIDTH_2(12)) u_m (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_m),
        .data1_i(data1[7:0]), .data2_i(data2[11:0]), .valid_o(vo_m), .ready_i(ready_i),
        .data_o(d_m), .borrow_o(b_m));

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: output with empty expected queue", name);
    endtask

    // Sampled at the falling edge: inputs and outputs are settled for the coming rising edge.
    task automatic monitor();
        int ds, du, dm;
        if (rst) begin
            exp_s_q.delete();
            exp_u_q.delete();
            exp_m_q.delete();
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            chk("hold_valid", 32'(vo_s), 32'd1);
            chk("hold_data", 32'({b_s, d_s}), 32'(prev_s));
        end
        if (vo_s && ready_i) begin
            if (exp_s_q.size() == 0) unexpected("out_s");
            else chk("out_s", 32'({b_s, d_s}), 32'(exp_s_q.pop_front()));
        end
        if (vo_u && ready_i) begin
            if (exp_u_q.size() == 0) unexpected("out_u");
            else chk("out_u", 32'({b_u, d_u}), 32'(exp_u_q.pop_front()));
        end
        if (vo_m && ready_i) begin
            if (exp_m_q.size() == 0) unexpected("out_m");
            else chk("out_m", 32'({b_m, d_m}), 32'(exp_m_q.pop_front()));
        end
        ds = int'($signed(data1)) - int'($signed(data2));
        du = int'(data1) - int'(data2);
        dm = int'(data1[7:0]) - int'(data2[11:0]);
        if (valid_i && rdy_s) exp_s_q.push_back({(ds < 0), ds[16:0]});
        if (valid_i && rdy_u) exp_u_q.push_back({(du < 0), du[16:0]});
        if (valid_i && rdy_m) exp_m_q.push_back({(dm < 0), dm[12:0]});
        prev_hold = vo_s && !ready_i;
        prev_s    = {b_s, d_s};
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom());
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic [16:0] es;
        logic        bs;
        logic [16:0] eu;
        logic        bu;
        logic [12:0] em;
        logic        bm;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int idx;
        logic seen_stall;
        logic accepted;

        tbl[0]  = '{16'd100,  16'hFFCE, 17'h00096, 1'b0, 17'h10096, 1'b1, 13'h1096, 1'b1};
        tbl[1]  = '{16'h8000, 16'h7FFF, 17'h10001, 1'b1, 17'h00001, 1'b0, 13'h1001, 1'b1};
        tbl[2]  = '{16'h7FFF, 16'h8000, 17'h0FFFF, 1'b0, 17'h1FFFF, 1'b1, 13'h00FF, 1'b0};
        tbl[3]  = '{16'd5,    16'd10,   17'h1FFFB, 1'b1, 17'h1FFFB, 1'b1, 13'h1FFB, 1'b1};
        tbl[4]  = '{16'hFFFF, 16'h0000, 17'h1FFFF, 1'b1, 17'h0FFFF, 1'b0, 13'h00FF, 1'b0};
        tbl[5]  = '{16'h0000, 16'h0000, 17'h00000, 1'b0, 17'h00000, 1'b0, 13'h0000, 1'b0};
        tbl[6]  = '{16'h8000, 16'h8000, 17'h00000, 1'b0, 17'h00000, 1'b0, 13'h0000, 1'b0};
        tbl[7]  = '{16'hFFFF, 16'hFFFF, 17'h00000, 1'b0, 17'h00000, 1'b0, 13'h1100, 1'b1};
        tbl[8]  = '{16'h0000, 16'hFFFF, 17'h00001, 1'b0, 17'h10001, 1'b1, 13'h1001, 1'b1};
        tbl[9]  = '{16'h8000, 16'h0001, 17'h17FFF, 1'b1, 17'h07FFF, 1'b0, 13'h1FFF, 1'b1};
        tbl[10] = '{16'h00FF, 16'h0FFF, 17'h1F100, 1'b1, 17'h1F100, 1'b1, 13'h1100, 1'b1};

        // ---- reset ----
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data1 = '0; data2 = '0;
        prev_hold = 1'b0; prev_s = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid", 32'(vo_s), 32'd0);
        chk("rst_data", 32'({b_s, d_s}), 32'd0);
        chk("rst_ready", 32'(rdy_s), 32'd1);
        chk("rst_data_m", 32'({b_m, d_m}), 32'd0);

        // ---- table vectors, one at a time, checking 2-cycle latency ----
        for (int i = 0; i < 11; i++) begin
            valid_i = 1'b1; data1 = tbl[i].d1; data2 = tbl[i].d2; ready_i = 1'b1;
            tick();
            valid_i = 1'b0;
            chk("lat1_valid", 32'(vo_s), 32'd0);
            tick();
            chk("lat2_valid", 32'(vo_s), 32'd1);
            chk("tbl_s", 32'({b_s, d_s}), 32'({tbl[i].bs, tbl[i].es}));
            chk("tbl_u", 32'({b_u, d_u}), 32'({tbl[i].bu, tbl[i].eu}));
            chk("tbl_m", 32'({b_m, d_m}), 32'({tbl[i].bm, tbl[i].em}));
        end
        tick();

        // ---- backpressure: 1..5 minus 0, ready_i low for cycles 2..6 ----
        idx = 1; seen_stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ready_i = !(k >= 2 && k <= 6);
            valid_i = (idx <= 5);
            data1 = 16'(idx); data2 = 16'd0;
            #1;
            if (!rdy_s) seen_stall = 1'b1;
            accepted = valid_i && rdy_s;
            tick();
            if (accepted) idx++;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) tick();
        chk("bp_all_accepted", 32'(idx), 32'd6);
        chk("bp_stall_seen", 32'(seen_stall), 32'd1);
        chk("bp_drained", 32'(exp_s_q.size()), 32'd0);

        // ---- reset with two results in flight ----
        valid_i = 1'b1; ready_i = 1'b0; data1 = 16'd7; data2 = 16'd3;
        tick();
        data1 = 16'd9; data2 = 16'd1;
        tick();
        valid_i = 1'b0;
        chk("pre_rst_valid", 32'(vo_s), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; ready_i = 1'b1;
        #1;
        chk("midrst_valid", 32'(vo_s), 32'd0);
        chk("midrst_data", 32'({b_s, d_s}), 32'd0);
        chk("midrst_ready", 32'(rdy_s), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_stale", 32'(vo_s | vo_u | vo_m), 32'd0);
        end

        // ---- randomized traffic with random backpressure ----
        for (int k = 0; k < 400; k++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            data1 = pick_operand();
            data2 = pick_operand();
            tick();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (4) tick();
        chk("rand_drain_s", 32'(exp_s_q.size()), 32'd0);
        chk("rand_drain_u", 32'(exp_u_q.size()), 32'd0);
        chk("rand_drain_m", 32'(exp_m_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
